// File: rtl/exec_issue_frontend_pkg.sv
// Shared definitions for the instruction-issue front end: switch field layout,
// opcode values, FSM encoding and the decoded instruction record.
package exec_issue_frontend_pkg;

    localparam logic OP_LD = 1'b0;
    localparam logic OP_ST = 1'b1;

    localparam int OP_BIT  = 14;
    localparam int RT_HI   = 13;
    localparam int RT_LO   = 10;
    localparam int BASE_HI = 9;
    localparam int BASE_LO = 6;
    localparam int OFF_HI  = 5;
    localparam int OFF_LO  = 0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    typedef struct packed {
        logic       is_store;
        logic [3:0] rt;
        logic [3:0] base;
        logic [5:0] offset;
    } instr_t;

    function automatic instr_t decode_sw(input logic [14:0] sw);
        instr_t instr;
        instr.is_store = (sw[OP_BIT] == OP_ST);
        instr.rt       = sw[RT_HI:RT_LO];
        instr.base     = sw[BASE_HI:BASE_LO];
        instr.offset   = sw[OFF_HI:OFF_LO];
        return instr;
    endfunction

endpackage

// File: rtl/exec_issue_frontend_btn_debounce.sv
// Two-flop synchroniser, counter debounce and one-cycle press pulse on the
// debounced 0->1 transition of a raw push-button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // The counter only survives while the synchronised input keeps disagreeing
    // with the debounced level, so any shorter excursion is forgotten.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/exec_issue_frontend.sv
// Turns the raw execute button and switch bank into one captured LD/ST
// instruction presented to the core on a valid/ready handshake.
module exec_issue_frontend
    import exec_issue_frontend_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CNT_W           = 20,
    parameter int ISSUE_CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset_btn,
    input  logic                   execute_btn,
    input  logic [14:0]            sw,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic                   is_store,
    output logic [3:0]             rt,
    output logic [3:0]             base,
    output logic [31:0]            offset_ext,
    output logic                   overrun,
    output logic [ISSUE_CNT_W-1:0] issue_count
);

    logic press;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk    (clk),
        .rst    (reset_btn),
        .btn_raw(execute_btn),
        .press  (press)
    );

    logic [0:0]             state_q, state_d;
    instr_t                 instr_q, instr_d;
    logic                   overrun_q, overrun_d;
    logic [ISSUE_CNT_W-1:0] count_q, count_d;

    // A press coinciding with acceptance reloads the fields and stays pending;
    // a press with no acceptance is dropped and recorded as an overrun.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        overrun_d = overrun_q;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                if (press) begin
                    instr_d = decode_sw(sw);
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (issue_ready) begin
                    count_d = count_q + 1'b1;
                    if (press) begin
                        instr_d = decode_sw(sw);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (press) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_btn) begin
        if (reset_btn) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            overrun_q <= overrun_d;
            count_q   <= count_d;
        end
    end

    assign issue_valid = (state_q == ST_PEND);
    assign is_store    = instr_q.is_store;
    assign rt          = instr_q.rt;
    assign base        = instr_q.base;
    assign offset_ext  = {26'd0, instr_q.offset};
    assign overrun     = overrun_q;
    assign issue_count = count_q;

endmodule

// File: tb/tb_exec_issue_frontend.sv
// Self-checking bench for exec_issue_frontend: directed scenarios plus
// randomized button/switch/ready traffic against a behavioural model.
module tb_exec_issue_frontend;

    localparam int D   = 2;
    localparam int ICW = 8;

    logic           clk = 1'b0;
    logic           reset_btn;
    logic           execute_btn;
    logic [14:0]    sw;
    logic           issue_valid;
    logic           issue_ready;
    logic           is_store;
    logic [3:0]     rt;
    logic [3:0]     base;
    logic [31:0]    offset_ext;
    logic           overrun;
    logic [ICW-1:0] issue_count;

    exec_issue_frontend #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (20),
        .ISSUE_CNT_W    (ICW)
    ) dut (
        .clk        (clk),
        .reset_btn  (reset_btn),
        .execute_btn(execute_btn),
        .sw         (sw),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .is_store   (is_store),
        .rt         (rt),
        .base       (base),
        .offset_ext (offset_ext),
        .overrun    (overrun),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: the debounced level flips once the last D synchronised
    // samples (raw samples two edges old) all disagree with it.
    bit             m_valid, m_store, m_overrun, m_press, m_level;
    bit [3:0]       m_rt, m_base;
    bit [5:0]       m_off;
    bit [ICW-1:0]   m_count;
    bit             hist[$];

    function automatic void modelReset();
        m_valid = 0; m_store = 0; m_overrun = 0; m_press = 0; m_level = 0;
        m_rt = 0; m_base = 0; m_off = 0; m_count = 0;
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
    endfunction

    function automatic void modelCapture(input bit [14:0] s);
        m_store = s[14];
        m_rt    = s[13:10];
        m_base  = s[9:6];
        m_off   = s[5:0];
    endfunction

    function automatic void modelStep(input bit btn, input bit [14:0] s, input bit rdy);
        bit allDiff;
        if (!m_valid) begin
            if (m_press) begin
                modelCapture(s);
                m_valid = 1;
            end
        end else if (rdy) begin
            m_count++;
            if (m_press) modelCapture(s);
            else m_valid = 0;
        end else if (m_press) begin
            m_overrun = 1;
        end
        hist.push_back(btn);
        allDiff = 1;
        for (int i = 0; i < D; i++)
            if (hist[hist.size() - 3 - i] == m_level) allDiff = 0;
        m_press = 0;
        if (allDiff) begin
            m_level = !m_level;
            m_press = m_level;
        end
        while (hist.size() > 32) void'(hist.pop_front());
    endfunction

    task automatic compareAll();
        checkOutput("issue_valid", issue_valid, m_valid);
        checkOutput("is_store", is_store, m_store);
        checkOutput("rt", rt, m_rt);
        checkOutput("base", base, m_base);
        checkOutput("offset_ext", offset_ext, {26'd0, m_off});
        checkOutput("overrun", overrun, m_overrun);
        checkOutput("issue_count", issue_count, m_count);
    endtask

    // One clock cycle: drive at the falling edge, model the rising edge,
    // then compare at the next falling edge.
    task automatic applyStimulus(input logic btn, input logic [14:0] s, input logic rdy);
        execute_btn = btn;
        sw          = s;
        issue_ready = rdy;
        @(posedge clk);
        modelStep(btn, s, rdy);
        @(negedge clk);
        compareAll();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, issue_valid, 0);
        checkOutput({tag, "_store"}, is_store, 0);
        checkOutput({tag, "_rt"}, rt, 0);
        checkOutput({tag, "_base"}, base, 0);
        checkOutput({tag, "_offset"}, offset_ext, 0);
        checkOutput({tag, "_overrun"}, overrun, 0);
        checkOutput({tag, "_count"}, issue_count, 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_btn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        modelReset();
        checkAllZero("reset");
        reset_btn = 1'b0;
    endtask

    initial begin
        logic [14:0] swA, swB, swC, swD;
        int          firstValid;
        bit          sawValid;
        bit [ICW-1:0] cntBefore;
        int          runLeft;
        logic        btnLvl;

        reset_btn   = 1'b1;
        execute_btn = 1'b0;
        issue_ready = 1'b0;
        sw          = '0;
        modelReset();
        doReset();

        // First press: exact latency, decoded fields, then hold while not ready.
        swA = 15'b0_0110_0000_000011;
        firstValid = -1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i < 3, swA, 1'b0);
            if (firstValid < 0 && issue_valid) firstValid = i;
        end
        checkOutput("latency_edges", firstValid, 4);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 15'h0, 1'b0);
            checkOutput("hold_valid", issue_valid, 1);
        end
        checkOutput("t1_store", is_store, 0);
        checkOutput("t1_rt", rt, 6);
        checkOutput("t1_base", base, 0);
        checkOutput("t1_offset", offset_ext, 3);
        applyStimulus(1'b0, 15'h0, 1'b1);
        checkOutput("accept_valid", issue_valid, 0);
        checkOutput("accept_count", issue_count, 1);

        // Switch changes while pending must not disturb the captured fields.
        swB = 15'b1_0001_0000_001000;
        for (int i = 0; i < 8; i++) applyStimulus(i < 3, swB, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 15'h7FFF, 1'b0);
        checkOutput("t3_store", is_store, 1);
        checkOutput("t3_rt", rt, 1);
        checkOutput("t3_base", base, 0);
        checkOutput("t3_offset", offset_ext, 8);
        applyStimulus(1'b0, 15'h7FFF, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 15'h0, 1'b0);

        // Single-cycle glitch is ignored.
        sawValid = 0;
        applyStimulus(1'b1, 15'h1234, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 15'h1234, 1'b0);
            if (issue_valid) sawValid = 1;
        end
        checkOutput("glitch_no_issue", sawValid, 0);

        // A long hold with ready always high yields exactly one accept.
        cntBefore = m_count;
        for (int i = 0; i < 50; i++) applyStimulus(1'b1, 15'h0ABC, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 15'h0ABC, 1'b1);
        checkOutput("hold_one_issue", issue_count, cntBefore + 1'b1);

        // Back-to-back: press lands together with ready.
        swA = 15'b0_0010_0011_000101;
        swB = 15'b1_1010_0101_111000;
        for (int i = 0; i < 10; i++) applyStimulus(i < 3, swA, 1'b0);
        cntBefore = m_count;
        for (int i = 0; i < 10; i++) applyStimulus(i < 3, swB, i == 4);
        checkOutput("b2b_valid", issue_valid, 1);
        checkOutput("b2b_rt", rt, 4'b1010);
        checkOutput("b2b_base", base, 4'b0101);
        checkOutput("b2b_count", issue_count, cntBefore + 1'b1);
        checkOutput("b2b_no_overrun", overrun, 0);

        // Press while pending and not ready: dropped, overrun sticks.
        swC = 15'h7FFF;
        for (int i = 0; i < 10; i++) applyStimulus(i < 3, swC, 1'b0);
        checkOutput("ovr_flag", overrun, 1);
        checkOutput("ovr_rt_kept", rt, 4'b1010);
        checkOutput("ovr_off_kept", offset_ext, 32'h38);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 15'h0, 1'b1);
        checkOutput("ovr_sticky", overrun, 1);

        // Asynchronous reset while pending, with the button held through it.
        swD = 15'b1_0101_1010_010101;
        for (int i = 0; i < 8; i++) applyStimulus(i < 3, swD, 1'b0);
        checkOutput("pre_reset_valid", issue_valid, 1);
        reset_btn   = 1'b1;
        execute_btn = 1'b1;
        #1;
        checkAllZero("async_reset");
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_btn = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, swD, 1'b0);
        checkOutput("held_through_reset", issue_valid, 1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 15'h0, 1'b1);

        // Randomized traffic.
        runLeft = 0;
        btnLvl  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (runLeft == 0) begin
                btnLvl  = 1'($urandom_range(0, 1));
                runLeft = $urandom_range(1, 6);
            end
            runLeft--;
            applyStimulus(btnLvl, 15'($urandom), $urandom_range(0, 9) < 3);
        end

        // Counter wrap after 256 accepts from reset.
        doReset();
        for (int n = 0; n < 256; n++)
            for (int i = 0; i < 7; i++) applyStimulus(i < 3, 15'($urandom), 1'b1);
        checkOutput("wrap_count", issue_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_issue_frontend.md
Name: exec_issue_frontend

Overview:
- Input-side conditioning for the board-level mini-MIPS: turns the raw execute_btn and sw[14:0] into one clean, handshaked instruction issue toward the processor core.
- Synchronises and debounces the button and detects the press edge.
- Captures and decodes the switch-encoded LD/ST instruction, then holds it on a valid/ready interface until the core accepts it.
- Sits between the board pins and the core; the LED readback path is outside this block.

Parameters:
DEBOUNCE_CYCLES, 2, consecutive stable synchronised samples required to change the debounced level (board build overrides, e.g. 1_000_000)
CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES
ISSUE_CNT_W, 8, width of the accepted-instruction counter

Ports:
clk  input  1  system clock
reset_btn  input  1  asynchronous, active-high reset
execute_btn  input  1  raw, asynchronous push-button
sw  input  15  sw[14:0] from board: [14]=op (0 LD, 1 ST), [13:10]=rt, [9:6]=base, [5:0]=offset
issue_valid  output  1  captured instruction pending
issue_ready  input  1  core accepts when high with issue_valid
is_store  output  1  captured sw[14]
rt  output  4  captured sw[13:10]
base  output  4  captured sw[9:6]
offset_ext  output  32  captured sw[5:0], zero-extended
overrun  output  1  sticky: a press arrived while an instruction was still pending
issue_count  output  ISSUE_CNT_W  accepted handshakes, wraps modulo 2^ISSUE_CNT_W

Behaviour:
- Reset (asynchronous, active-high): all outputs 0. Sync flops, debounced level, counter and captured fields all 0.
- Synchroniser: execute_btn passes through 2 flops to give btn_s.
- Debounce:
  - If btn_s differs from the debounced level, the counter increments. Otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while they still differ, the level toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES samples is ignored.
- Press pulse: exactly one cycle, on the 0->1 transition of the debounced level. Release produces nothing.
- FSM states:
  - IDLE: press -> capture sw into the field registers, go to PEND. issue_valid=1 from the next cycle.
  - PEND: issue_valid=1 and all fields held stable; sw changes are ignored.
    - issue_ready=1 -> issue_count++, return to IDLE, issue_valid=0 next cycle.
    - Press without ready -> press dropped, overrun<=1, stay PEND.
    - Press and issue_ready in the same cycle -> current instruction accepted (count++), new sw captured, stay PEND (back-to-back). overrun not set.
- Latency (DEBOUNCE_CYCLES=2): execute_btn sampled high at edge N -> issue_valid high after edge N+4. That is 2 sync + DEBOUNCE_CYCLES + 1 capture, minus overlap. The bench checks the exact edge.
- Holding the button produces one issue only. A new press needs a debounced release first.
- overrun clears only on reset.
- issue_count: 255 -> 0 on the next accept, with no flag.
- Reset mid-PEND: the instruction is discarded, issue_valid drops immediately (asynchronous) and the FSM goes to IDLE.
- While reset_btn is high, button activity has no effect. After release, a button still held is treated as a new press only after it is debounced from the 0 level.

Decomposition:
- Shared package holds:
  - opcode localparams OP_LD=1'b0, OP_ST=1'b1
  - the sw field bit-position constants (OP_BIT=14, RT_HI/LO, BASE_HI/LO, OFF_HI/LO)
  - FSM state encoding IDLE/PEND
- One natural sub-module: btn_debounce (synchroniser + counter + rising-edge pulse), parameterised by DEBOUNCE_CYCLES and CNT_W. The top instantiates it and holds the FSM, capture registers and counters.

Test Plan:
- Reset, then sw=15'b0_0110_0000_000011, pulse execute_btn 3 cycles, issue_ready=0 -> issue_valid=1 at the specified edge, is_store=0, rt=6, base=0, offset_ext=3; holds for 10 cycles.
- Continue the previous case: assert issue_ready 1 cycle -> issue_valid=0 next cycle, issue_count=1.
- sw=15'b1_0001_0000_001000, press, then change sw to all 1s while pending -> fields stay is_store=1, rt=1, base=0, offset_ext=8 until accepted.
- 1-cycle glitch on execute_btn -> no issue_valid. Button held 50 cycles -> exactly one issue.
- Second press while PEND and no ready -> overrun=1 and the original fields unchanged. Press coincident with ready -> count++, new fields captured, issue_valid stays 1.
- Assert reset_btn mid-PEND -> issue_valid=0 asynchronously and all outputs 0. Run 256 accepts -> issue_count wraps to 0.
